// File: rtl/dma_channel_regbank_pkg.sv
// rtl/dma_channel_regbank_pkg.sv - shared constants and types for the DMA channel register bank
package dma_channel_regbank_pkg;

    localparam int CHANNELS_DEF     = 4;
    localparam int DATAWIDTH_DEF    = 8;
    localparam int ADDRESSWIDTH_DEF = 16;

    typedef enum logic [1:0] {
        REG_ADDR   = 2'b00,
        REG_COUNT  = 2'b01,
        REG_MODE   = 2'b10,
        REG_STATUS = 2'b11
    } reg_type_e;

    typedef struct packed {
        logic decrement;
        logic auto_init;
    } mode_bits_t;

    // Channel select width; a single-channel bank still carries a 1-bit select.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_channel_slice.sv
// rtl/dma_channel_slice.sv - one channel's base/current address and count, mode, TC and reload
module dma_channel_slice
    import dma_channel_regbank_pkg::*;
#(
    parameter int DATAWIDTH    = DATAWIDTH_DEF,
    parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATAWIDTH-1:0]    data,
    input  logic                    wr_addr_lo,
    input  logic                    wr_addr_hi,
    input  logic                    wr_count_lo,
    input  logic                    wr_count_hi,
    input  logic                    wr_mode,
    input  logic                    xfer,
    output logic [ADDRESSWIDTH-1:0] cur_addr,
    output logic [ADDRESSWIDTH-1:0] cur_count,
    output mode_bits_t              mode,
    output logic                    tc
);

    localparam int DW = DATAWIDTH;
    localparam int AW = ADDRESSWIDTH;

    logic [AW-1:0] base_addr;
    logic [AW-1:0] base_count;
    logic          reload;

    // TC is judged on the count before this transfer's decrement.
    assign tc     = xfer && (cur_count == '0);
    assign reload = tc && mode.auto_init;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_addr  <= '0;
            base_count <= '0;
            cur_addr   <= '0;
            cur_count  <= '0;
            mode       <= '0;
        end else begin
            // A CPU byte write owns the whole register this cycle; the transfer step is dropped.
            if (wr_addr_lo) begin
                base_addr[DW-1:0] <= data;
                cur_addr          <= {cur_addr[AW-1:DW], data};
            end else if (wr_addr_hi) begin
                base_addr[AW-1:DW] <= data;
                cur_addr           <= {data, cur_addr[DW-1:0]};
            end else if (reload) begin
                cur_addr <= base_addr;
            end else if (xfer) begin
                cur_addr <= mode.decrement ? cur_addr - AW'(1) : cur_addr + AW'(1);
            end

            if (wr_count_lo) begin
                base_count[DW-1:0] <= data;
                cur_count          <= {cur_count[AW-1:DW], data};
            end else if (wr_count_hi) begin
                base_count[AW-1:DW] <= data;
                cur_count           <= {data, cur_count[DW-1:0]};
            end else if (reload) begin
                cur_count <= base_count;
            end else if (xfer) begin
                cur_count <= cur_count - AW'(1);
            end

            if (wr_mode) begin
                mode <= mode_bits_t'(data[1:0]);
            end
        end
    end

endmodule

// File: rtl/dma_channel_regbank.sv
// rtl/dma_channel_regbank.sv - per-channel DMA register bank with byte pointer, read mux and TC status
module dma_channel_regbank
    import dma_channel_regbank_pkg::*;
#(
    parameter int CHANNELS     = CHANNELS_DEF,
    parameter int DATAWIDTH    = DATAWIDTH_DEF,
    parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEF
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              wrEn,
    input  logic                              rdEn,
    input  logic [1:0]                        regType,
    input  logic [chan_width(CHANNELS)-1:0]   regChannel,
    input  logic [DATAWIDTH-1:0]              dataIn,
    input  logic                              clearFF,
    output logic [DATAWIDTH-1:0]              dataOut,
    input  logic                              xferStrobe,
    input  logic [chan_width(CHANNELS)-1:0]   activeChannel,
    output logic [ADDRESSWIDTH-1:0]           currentAddrOut,
    output logic                              tcPulse,
    output logic [CHANNELS-1:0]               tcStatus,
    output logic [CHANNELS-1:0]               maskOut
);

    localparam int CH_W  = chan_width(CHANNELS);
    localparam int SLOTS = 2 ** CH_W;
    localparam int DW    = DATAWIDTH;
    localparam int AW    = ADDRESSWIDTH;

    reg_type_e             rtype;
    logic                  ptr;
    logic                  rd_access;
    logic                  byte_reg;
    logic                  tc_pulse_q;
    logic [CHANNELS-1:0]   tc_status;
    logic [CHANNELS-1:0]   mask;
    logic [CHANNELS-1:0]   tc_vec;
    logic [CHANNELS-1:0]   count_hi_wr;
    logic [DW-1:0]         status_byte;
    logic [AW-1:0]         cur_addr  [SLOTS];
    logic [AW-1:0]         cur_count [SLOTS];
    mode_bits_t            mode      [SLOTS];

    assign rtype     = reg_type_e'(regType);
    assign rd_access = rdEn && !wrEn;
    assign byte_reg  = (rtype == REG_ADDR) || (rtype == REG_COUNT);

    // Unused select codes (non power-of-two channel counts) read back as zero.
    for (genvar c = 0; c < SLOTS; c++) begin : g_chan
        if (c < CHANNELS) begin : g_slice
            logic sel;
            assign sel = wrEn && (regChannel == CH_W'(c));
            assign count_hi_wr[c] = sel && (rtype == REG_COUNT) && ptr;

            dma_channel_slice #(
                .DATAWIDTH   (DATAWIDTH),
                .ADDRESSWIDTH(ADDRESSWIDTH)
            ) u_slice (
                .clk        (CLK),
                .reset      (RESET),
                .data       (dataIn),
                .wr_addr_lo (sel && (rtype == REG_ADDR) && !ptr),
                .wr_addr_hi (sel && (rtype == REG_ADDR) && ptr),
                .wr_count_lo(sel && (rtype == REG_COUNT) && !ptr),
                .wr_count_hi(count_hi_wr[c]),
                .wr_mode    (sel && (rtype == REG_MODE)),
                .xfer       (xferStrobe && (activeChannel == CH_W'(c))),
                .cur_addr   (cur_addr[c]),
                .cur_count  (cur_count[c]),
                .mode       (mode[c]),
                .tc         (tc_vec[c])
            );
        end else begin : g_pad
            assign cur_addr[c]  = '0;
            assign cur_count[c] = '0;
            assign mode[c]      = '0;
        end
    end

    for (genvar i = 0; i < DW; i++) begin : g_status
        if (i < CHANNELS) begin : g_bit
            assign status_byte[i] = tc_status[i];
        end else begin : g_zero
            assign status_byte[i] = 1'b0;
        end
    end

    assign currentAddrOut = cur_addr[activeChannel];
    assign tcPulse        = tc_pulse_q && !RESET;
    assign tcStatus       = tc_status;
    assign maskOut        = mask;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr        <= 1'b0;
            dataOut    <= '0;
            tc_status  <= '0;
            mask       <= '0;
            tc_pulse_q <= 1'b0;
        end else begin
            if (clearFF) begin
                ptr <= 1'b0;
            end else if ((wrEn || rdEn) && byte_reg) begin
                ptr <= !ptr;
            end

            if (rd_access) begin
                case (rtype)
                    REG_ADDR:   dataOut <= ptr ? cur_addr[regChannel][AW-1:DW]
                                               : cur_addr[regChannel][DW-1:0];
                    REG_COUNT:  dataOut <= ptr ? cur_count[regChannel][AW-1:DW]
                                               : cur_count[regChannel][DW-1:0];
                    REG_MODE:   dataOut <= {{(DW-2){1'b0}}, mode[regChannel]};
                    REG_STATUS: dataOut <= status_byte;
                    default:    ;
                endcase
            end

            // A TC landing in the same cycle as a status read survives the clear.
            tc_status <= ((rd_access && (rtype == REG_STATUS)) ? '0 : tc_status) | tc_vec;

            for (int c = 0; c < CHANNELS; c++) begin
                if (tc_vec[c] && !mode[c].auto_init) begin
                    mask[c] <= 1'b1;
                end else if (count_hi_wr[c]) begin
                    mask[c] <= 1'b0;
                end
            end

            tc_pulse_q <= |tc_vec;
        end
    end

endmodule

// File: tb/tb_dma_channel_regbank.sv
// tb/tb_dma_channel_regbank.sv - directed and randomized checks of dma_channel_regbank against a reference model
module tb_dma_channel_regbank;

    logic        CLK;
    logic        RESET;
    logic        wrEn;
    logic        rdEn;
    logic [1:0]  regType;
    logic [1:0]  regChannel;
    logic [7:0]  dataIn;
    logic        clearFF;
    logic [7:0]  dataOut;
    logic        xferStrobe;
    logic [1:0]  activeChannel;
    logic [15:0] currentAddrOut;
    logic        tcPulse;
    logic [3:0]  tcStatus;
    logic [3:0]  maskOut;

    dma_channel_regbank #(
        .CHANNELS    (4),
        .DATAWIDTH   (8),
        .ADDRESSWIDTH(16)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .wrEn          (wrEn),
        .rdEn          (rdEn),
        .regType       (regType),
        .regChannel    (regChannel),
        .dataIn        (dataIn),
        .clearFF       (clearFF),
        .dataOut       (dataOut),
        .xferStrobe    (xferStrobe),
        .activeChannel (activeChannel),
        .currentAddrOut(currentAddrOut),
        .tcPulse       (tcPulse),
        .tcStatus      (tcStatus),
        .maskOut       (maskOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [15:0] m_ba [4];
    logic [15:0] m_ca [4];
    logic [15:0] m_bc [4];
    logic [15:0] m_cc [4];
    logic        m_auto [4];
    logic        m_dec  [4];
    logic [3:0]  m_tcs;
    logic [3:0]  m_mask;
    logic        m_ptr;
    logic [7:0]  m_dout;
    logic        m_pulse;

    task automatic model_apply(input logic wr, input logic rd, input logic [1:0] rt,
                               input logic [1:0] ch, input logic [7:0] din, input logic clr,
                               input logic xs, input logic [1:0] ach, input logic rst);
        logic        tc;
        logic        tc_mask;
        logic [15:0] na [4];
        logic [15:0] nc [4];
        logic [3:0]  nmask;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_ba[c] = 16'h0; m_ca[c] = 16'h0; m_bc[c] = 16'h0; m_cc[c] = 16'h0;
                m_auto[c] = 1'b0; m_dec[c] = 1'b0;
            end
            m_tcs = 4'h0; m_mask = 4'h0; m_ptr = 1'b0; m_dout = 8'h0; m_pulse = 1'b0;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            na[c] = m_ca[c];
            nc[c] = m_cc[c];
        end
        nmask   = m_mask;
        tc      = xs && (m_cc[ach] == 16'h0);
        tc_mask = tc && !m_auto[ach];
        if (xs) begin
            if (tc && m_auto[ach]) begin
                na[ach] = m_ba[ach];
                nc[ach] = m_bc[ach];
            end else begin
                na[ach] = m_dec[ach] ? m_ca[ach] - 16'd1 : m_ca[ach] + 16'd1;
                nc[ach] = m_cc[ach] - 16'd1;
            end
        end
        if (wr) begin
            case (rt)
                2'd0: begin
                    if (m_ptr) begin m_ba[ch][15:8] = din; na[ch] = {din, m_ca[ch][7:0]}; end
                    else       begin m_ba[ch][7:0]  = din; na[ch] = {m_ca[ch][15:8], din}; end
                end
                2'd1: begin
                    if (m_ptr) begin m_bc[ch][15:8] = din; nc[ch] = {din, m_cc[ch][7:0]}; nmask[ch] = 1'b0; end
                    else       begin m_bc[ch][7:0]  = din; nc[ch] = {m_cc[ch][15:8], din}; end
                end
                2'd2: begin m_auto[ch] = din[0]; m_dec[ch] = din[1]; end
                default: ;
            endcase
        end else if (rd) begin
            case (rt)
                2'd0: m_dout = m_ptr ? m_ca[ch][15:8] : m_ca[ch][7:0];
                2'd1: m_dout = m_ptr ? m_cc[ch][15:8] : m_cc[ch][7:0];
                2'd2: m_dout = {6'b0, m_dec[ch], m_auto[ch]};
                default: begin m_dout = {4'b0, m_tcs}; m_tcs = 4'h0; end
            endcase
        end
        if (tc)      m_tcs[ach] = 1'b1;
        if (tc_mask) nmask[ach] = 1'b1;
        if (clr)                          m_ptr = 1'b0;
        else if ((wr || rd) && rt < 2'd2) m_ptr = ~m_ptr;
        m_mask = nmask;
        for (int c = 0; c < 4; c++) begin
            m_ca[c] = na[c];
            m_cc[c] = nc[c];
        end
        m_pulse = tc;
    endtask

    task automatic check_outputs();
        check("data_out",  dataOut,        m_dout);
        check("cur_addr",  currentAddrOut, m_ca[activeChannel]);
        check("tc_pulse",  tcPulse,        m_pulse & ~RESET);
        check("tc_status", tcStatus,       m_tcs);
        check("mask",      maskOut,        m_mask);
    endtask

    task automatic step(input logic wr, input logic rd, input logic [1:0] rt,
                        input logic [1:0] ch, input logic [7:0] din, input logic clr,
                        input logic xs, input logic [1:0] ach, input logic rst);
        wrEn = wr; rdEn = rd; regType = rt; regChannel = ch; dataIn = din;
        clearFF = clr; xferStrobe = xs; activeChannel = ach; RESET = rst;
        model_apply(wr, rd, rt, ch, din, clr, xs, ach, rst);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic cpu_wr(input logic [1:0] rt, input logic [1:0] ch, input logic [7:0] d);
        step(1'b1, 1'b0, rt, ch, d, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic cpu_rd(input logic [1:0] rt, input logic [1:0] ch);
        step(1'b0, 1'b1, rt, ch, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic strobe(input logic [1:0] ach);
        step(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, ach, 1'b0);
    endtask

    initial begin
        logic       wr, rd, clr, xs, rst;
        logic [1:0] rt, ch, ach;
        logic [7:0] din;
        int         r;

        step(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
        check("rst_data",   dataOut, 8'h00);
        check("rst_status", tcStatus, 4'h0);
        check("rst_mask",   maskOut, 4'h0);

        // Address write/read-back through the byte pointer
        step(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
        cpu_wr(2'd0, 2'd2, 8'h34);
        cpu_wr(2'd0, 2'd2, 8'h12);
        cpu_rd(2'd0, 2'd2);
        check("t1_rd_lo", dataOut, 8'h34);
        cpu_rd(2'd0, 2'd2);
        check("t1_rd_hi", dataOut, 8'h12);
        cpu_rd(2'd0, 2'd2);
        check("t1_ptr_back_lo", dataOut, 8'h34);
        step(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);

        // Count 2 on ch0 gives three transfers then TC with mask
        cpu_wr(2'd1, 2'd0, 8'h02);
        cpu_wr(2'd1, 2'd0, 8'h00);
        cpu_wr(2'd2, 2'd0, 8'h00);
        strobe(2'd0);
        check("t2_addr1", currentAddrOut, 16'h0001);
        check("t2_nopulse1", tcPulse, 1'b0);
        strobe(2'd0);
        check("t2_nopulse2", tcPulse, 1'b0);
        strobe(2'd0);
        check("t2_addr3", currentAddrOut, 16'h0003);
        check("t2_pulse", tcPulse, 1'b1);
        check("t2_status0", tcStatus[0], 1'b1);
        check("t2_mask0", maskOut[0], 1'b1);
        step(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        check("t2_pulse_once", tcPulse, 1'b0);

        // Autoinit with decrement on ch1
        cpu_wr(2'd0, 2'd1, 8'h00);
        cpu_wr(2'd0, 2'd1, 8'h10);
        cpu_wr(2'd1, 2'd1, 8'h01);
        cpu_wr(2'd1, 2'd1, 8'h00);
        cpu_wr(2'd2, 2'd1, 8'h03);
        strobe(2'd1);
        check("t3_dec", currentAddrOut, 16'h0FFF);
        strobe(2'd1);
        check("t3_reload", currentAddrOut, 16'h1000);
        check("t3_pulse", tcPulse, 1'b1);
        check("t3_mask1", maskOut[1], 1'b0);
        cpu_rd(2'd1, 2'd1);
        check("t3_cnt_lo", dataOut, 8'h01);
        cpu_rd(2'd1, 2'd1);
        check("t3_cnt_hi", dataOut, 8'h00);

        // Address wrap and count wrap on ch2
        cpu_wr(2'd0, 2'd2, 8'hFF);
        cpu_wr(2'd0, 2'd2, 8'hFF);
        strobe(2'd2);
        check("t4_wrap", currentAddrOut, 16'h0000);
        check("t4_pulse", tcPulse, 1'b1);
        cpu_rd(2'd1, 2'd2);
        check("t4_cnt_lo", dataOut, 8'hFF);
        cpu_rd(2'd1, 2'd2);
        check("t4_cnt_hi", dataOut, 8'hFF);

        // Status read colliding with a ch3 TC
        step(1'b0, 1'b1, 2'd3, 2'd0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0);
        check("t5_prior", dataOut, 8'h07);
        check("t5_status", tcStatus, 4'b1000);

        // Reset right after a TC strobe suppresses the pulse
        cpu_wr(2'd1, 2'd3, 8'h00);
        cpu_wr(2'd1, 2'd3, 8'h00);
        strobe(2'd3);
        RESET = 1'b1;
        #1;
        check("t6_pulse_gated", tcPulse, 1'b0);
        step(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b1);
        check("t6_pulse", tcPulse, 1'b0);
        check("t6_status", tcStatus, 4'h0);
        check("t6_mask", maskOut, 4'h0);
        check("t6_data", dataOut, 8'h00);
        check("t6_addr", currentAddrOut, 16'h0000);

        for (int i = 0; i < 800; i++) begin
            r   = $urandom_range(0, 99);
            wr  = (r < 30) || (r >= 97);
            rd  = ((r >= 30) && (r < 55)) || (r >= 97);
            rt  = 2'($urandom_range(0, 3));
            ch  = 2'($urandom_range(0, 3));
            din = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            clr = ($urandom_range(0, 19) == 0);
            xs  = ($urandom_range(0, 2) == 0);
            ach = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 249) == 0);
            step(wr, rd, rt, ch, din, clr, xs, ach, rst);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dma_channel_regbank.md
Name: dma_channel_regbank

Overview:
Parametrised per-channel register bank for the DMA controller. It replaces the fixed 4-channel address/word-count storage with a CHANNELS-wide generated bank. Beyond storage it adds a byte-pointer flip-flop, address increment/decrement, terminal-count (TC) detection, autoinitialize reload, and sticky TC status with per-channel auto-mask. It sits between the CPU-side data/address buffers and the transfer-timing FSM.

Parameters:
CHANNELS, 4, number of DMA channels (>=1)
DATAWIDTH, 8, CPU data bus width
ADDRESSWIDTH, 16, address and word-count width; must equal 2*DATAWIDTH

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous active-high reset
wrEn  input  1  CPU register write strobe, one cycle per byte
rdEn  input  1  CPU register read strobe, one cycle per byte
regType  input  2  00 address, 01 word count, 10 mode, 11 status (read only)
regChannel  input  $clog2(CHANNELS)  target channel for CPU access (min width 1)
dataIn  input  DATAWIDTH  write data
clearFF  input  1  clear byte-pointer flip-flop
dataOut  output  DATAWIDTH  registered read data
xferStrobe  input  1  one transfer completed on activeChannel
activeChannel  input  $clog2(CHANNELS)  channel currently being serviced
currentAddrOut  output  ADDRESSWIDTH  current address of activeChannel (combinational)
tcPulse  output  1  one-cycle TC indication
tcStatus  output  CHANNELS  sticky TC bits
maskOut  output  CHANNELS  per-channel request mask

Behaviour:
- Reset: all base/current registers, mode, tcStatus, maskOut, byte pointer, dataOut and tcPulse go to 0.
- Byte pointer (ptr):
  - ptr=0 selects the low byte [DATAWIDTH-1:0]; ptr=1 selects the high byte.
  - ptr toggles after every wrEn or rdEn with regType 00 or 01.
  - clearFF forces ptr=0 and has priority over a toggle in the same cycle.
- Address / word-count writes: update the selected byte of both base and current of regChannel in the same cycle.
  - A high-byte write to the word count also clears maskOut[regChannel].
- Mode write (regType 10): dataIn[0]=autoInit, dataIn[1]=decrement; other bits ignored. ptr is unchanged.
- Reads:
  - Address / word count return the selected byte of the current register.
  - Status read returns {zero-pad, tcStatus} truncated to DATAWIDTH, then clears tcStatus.
  - dataOut is valid the cycle after rdEn and holds until the next read.
  - wrEn and rdEn asserted together is illegal; the write wins and ptr toggles once.
- Transfer on xferStrobe:
  - Current address of activeChannel changes by +1, or -1 when decrement=1, modulo 2^ADDRESSWIDTH.
  - Current word count decrements by 1.
  - TC fires when the word count was 0 before the decrement (N programmed = N+1 transfers). The count wraps to all-ones.
- On TC:
  - tcPulse=1 in the following cycle.
  - tcStatus[ch] is set.
  - If autoInit=1: current address and count reload from base in that same update (the reload replaces the increment).
  - If autoInit=0: maskOut[ch] is set.
- Collisions:
  - CPU write and xferStrobe to the same channel and register in one cycle: the CPU write wins for that register; the other register still updates.
  - Status read in the same cycle a TC sets a bit: the new bit survives the clear.
- Reset mid-transfer: everything returns to reset values; no tcPulse is generated.
- currentAddrOut has zero latency and reflects the registered current address of activeChannel.

Decomposition:
- dmaRegConfigPkg holds:
  - width and channel constants
  - regType enum (REG_ADDR, REG_COUNT, REG_MODE, REG_STATUS)
  - packed modeBits struct {decrement, autoInit}
- Sub-module dma_channel_slice: one channel's base/current address and count, mode, inc/dec, TC and reload logic. It is generated CHANNELS times.
- The top level keeps ptr, the read mux, tcStatus/maskOut and tcPulse.

Test Plan:
- Reset, clearFF, write addr ch2 bytes 0x34 then 0x12, read back two bytes -> dataOut 0x34 then 0x12; ptr returns to 0.
- Count ch0=0x0002, mode 0b00, three xferStrobe -> addr 0x0000→0x0003; tcPulse once, one cycle after the third strobe; tcStatus[0]=1; maskOut[0]=1.
- ch1 addr 0x1000, count 0x0001, mode autoInit|decrement, two strobes -> addr 0x0FFF then reloads 0x1000, count reloads 0x0001; maskOut[1]=0.
- Addr 0xFFFF with increment, one strobe -> 0x0000 (wrap); count 0x0000 with one strobe -> TC, count 0xFFFF.
- Status read in the same cycle as a ch3 TC -> dataOut shows prior bits; tcStatus afterwards = 0b1000.
- RESET asserted the cycle after a strobe that causes TC -> tcPulse stays 0; all outputs are 0 in the next cycle.
